// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the mode-0 SPI master.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_BITS        = 8;
    localparam int CLK_DIV_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        SCLK_HIGH = 3'd2,
        SCLK_LOW  = 3'd3,
        HOLD      = 3'd4,
        DONE      = 3'd5
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_master_mode0.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_mode0
//  Description : Single-byte SPI master, mode 0, MSB first, active-low cs.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_mode0
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data2send,
    input  logic       miso,
    output logic       done,
    output logic       sclk,
    output logic       mosi,
    output logic       cs,
    output logic [7:0] data2receive
);

    localparam int                 c_cnt_w      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_reload = c_cnt_w'(CLK_DIV - 1);
    localparam logic [3:0]         c_bits_all   = 4'(SPI_BITS);

    spi_state_t            r_state_q,  w_state_d;
    logic [c_cnt_w-1:0]    r_cnt_q,    w_cnt_d;
    logic [3:0]            r_bits_q,   w_bits_d;
    logic [SPI_BITS-1:0]   r_tx_q,     w_tx_d;
    logic [SPI_BITS-1:0]   r_rx_q,     w_rx_d;
    logic [SPI_BITS-1:0]   r_rx_out_q, w_rx_out_d;
    logic                  r_sclk_q,   w_sclk_d;
    logic                  r_cs_q,     w_cs_d;
    logic                  r_mosi_q,   w_mosi_d;
    logic                  r_done_q,   w_done_d;
    logic                  w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_cnt_q    <= '0;
            r_bits_q   <= '0;
            r_tx_q     <= '0;
            r_rx_q     <= '0;
            r_rx_out_q <= '0;
            r_sclk_q   <= 1'b0;
            r_cs_q     <= 1'b1;
            r_mosi_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_bits_q   <= w_bits_d;
            r_tx_q     <= w_tx_d;
            r_rx_q     <= w_rx_d;
            r_rx_out_q <= w_rx_out_d;
            r_sclk_q   <= w_sclk_d;
            r_cs_q     <= w_cs_d;
            r_mosi_q   <= w_mosi_d;
            r_done_q   <= w_done_d;
        end
    end

    // Each non-idle phase lasts CLK_DIV cycles; the tick marks its last cycle.
    assign w_tick = (r_cnt_q == '0);

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_bits_d   = r_bits_q;
        w_tx_d     = r_tx_q;
        w_rx_d     = r_rx_q;
        w_rx_out_d = r_rx_out_q;
        w_sclk_d   = r_sclk_q;
        w_cs_d     = r_cs_q;
        w_mosi_d   = r_mosi_q;
        w_done_d   = 1'b0;

        case (r_state_q)
            IDLE: begin
                w_sclk_d = 1'b0;
                w_cs_d   = 1'b1;
                w_mosi_d = 1'b0;
                if (start) begin
                    w_tx_d    = data2send;
                    w_cs_d    = 1'b0;
                    w_mosi_d  = data2send[SPI_BITS-1];
                    w_cnt_d   = c_cnt_reload;
                    w_bits_d  = '0;
                    w_state_d = SETUP;
                end
            end
            SETUP, SCLK_LOW: begin
                if (w_tick) begin
                    // Rising sclk edge: miso is captured on this same clk edge.
                    w_sclk_d  = 1'b1;
                    w_rx_d    = {r_rx_q[SPI_BITS-2:0], miso};
                    w_bits_d  = r_bits_q + 4'd1;
                    w_cnt_d   = c_cnt_reload;
                    w_state_d = SCLK_HIGH;
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
            SCLK_HIGH: begin
                if (w_tick) begin
                    w_sclk_d = 1'b0;
                    w_cnt_d  = c_cnt_reload;
                    if (r_bits_q < c_bits_all) begin
                        w_tx_d    = {r_tx_q[SPI_BITS-2:0], 1'b0};
                        w_mosi_d  = r_tx_q[SPI_BITS-2];
                        w_state_d = SCLK_LOW;
                    end else begin
                        w_state_d = HOLD;
                    end
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (w_tick) begin
                    w_cs_d     = 1'b1;
                    w_mosi_d   = 1'b0;
                    w_done_d   = 1'b1;
                    w_rx_out_d = r_rx_q;
                    w_state_d  = DONE;
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign done         = r_done_q;
    assign sclk         = r_sclk_q;
    assign mosi         = r_mosi_q;
    assign cs           = r_cs_q;
    assign data2receive = r_rx_out_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_mode0.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_mode0
//  Description : Scoreboard bench for spi_master_mode0 at CLK_DIV=2 and 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_mode0;

    typedef struct packed {
        int         id;
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start;
    logic [7:0] d2s [2];
    logic [1:0] slave_miso;
    logic [1:0] stim_miso;
    logic [7:0] slave_byte [2];
    logic [1:0] gap_check;
    wire  [1:0] miso, sclk, cs, mosi, done;
    wire  [7:0] d2r [2];

    exp_t exp_q [$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    int         m_cs_low [2];
    int         m_gap    [2];
    int         m_rises  [2];
    int         m_idx    [2];
    logic [7:0] m_txcap  [2];
    logic [1:0] m_prev_cs, m_prev_sclk, m_prev_done, m_bad;

    always #5 clk = ~clk;

    // Instance 0 runs at CLK_DIV=2, instance 1 at CLK_DIV=1.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_master_mode0 #(.CLK_DIV((g == 0) ? 2 : 1)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start[g]),
            .data2send    (d2s[g]),
            .miso         (miso[g]),
            .done         (done[g]),
            .sclk         (sclk[g]),
            .mosi         (mosi[g]),
            .cs           (cs[g]),
            .data2receive (d2r[g])
        );
        assign miso[g] = cs[g] ? stim_miso[g] : slave_miso[g];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Slave model plus monitor: serves slave_byte MSB first, changing after each
    // falling sclk, and checks every completed frame against the scoreboard.
    initial begin
        m_prev_cs   = 2'b11;
        m_prev_sclk = 2'b00;
        m_prev_done = 2'b00;
        m_bad       = 2'b00;
        slave_miso  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_cs_low[i] = 0; m_gap[i] = 0; m_rises[i] = 0; m_idx[i] = 0; m_txcap[i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (m_prev_cs[i] && !cs[i]) begin
                    if (gap_check[i]) check("cs_gap", m_gap[i], 2);
                    m_cs_low[i] = 0; m_rises[i] = 0; m_idx[i] = 0;
                    m_txcap[i] = 8'h00; m_bad[i] = 1'b0;
                    slave_miso[i] = slave_byte[i][7];
                end
                if (!cs[i]) begin m_cs_low[i]++; m_gap[i] = 0; end
                else m_gap[i]++;
                if (sclk[i] && !m_prev_sclk[i]) begin
                    m_txcap[i] = {m_txcap[i][6:0], mosi[i]};
                    m_rises[i]++;
                end
                if (!sclk[i] && m_prev_sclk[i]) begin
                    m_idx[i]++;
                    if (m_idx[i] < 8) slave_miso[i] = slave_byte[i][7 - m_idx[i]];
                end
                if (sclk[i] && cs[i]) m_bad[i] = 1'b1;
                if (done[i]) begin
                    check("done_width", m_prev_done[i], 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", exp_q.size(), 1);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("done_inst", i, e.id);
                        check("rx_byte", d2r[i], e.rx);
                        check("mosi_bits", m_txcap[i], e.tx);
                        check("cs_low_cycles", m_cs_low[i], 17 * ((i == 0) ? 2 : 1));
                        check("sclk_pulses", m_rises[i], 8);
                        check("sclk_while_cs_high", m_bad[i], 0);
                    end
                end
                m_prev_cs[i]   = cs[i];
                m_prev_sclk[i] = sclk[i];
                m_prev_done[i] = done[i];
            end
        end
    end

    task automatic pulse_start(input int id, input logic [7:0] tx);
        @(negedge clk);
        d2s[id]   = tx;
        start[id] = 1'b1;
        @(negedge clk);
        start[id] = 1'b0;
    endtask

    task automatic wait_done(input int id);
        int n = 0;
        while (n < 200 && !done[id]) begin @(negedge clk); n++; end
        check("done_seen", done[id], 1);
        @(negedge clk);
    endtask

    task automatic wait_cs_low(input int id);
        int n = 0;
        while (n < 50 && cs[id]) begin @(negedge clk); n++; end
        check("cs_fall_seen", cs[id], 0);
    endtask

    task automatic frame(input int id, input logic [7:0] tx, input logic [7:0] rx);
        slave_byte[id] = rx;
        exp_q.push_back('{id: id, tx: tx, rx: rx});
        pulse_start(id, tx);
        wait_done(id);
    endtask

    task automatic check_reset_outputs(input int id);
        check("rst_sclk", sclk[id], 0);
        check("rst_cs",   cs[id],   1);
        check("rst_mosi", mosi[id], 0);
        check("rst_done", done[id], 0);
        check("rst_rx",   d2r[id],  8'h00);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 2'b00;
        d2s        = '{8'h00, 8'h00};
        stim_miso  = 2'b00;
        gap_check  = 2'b00;
        slave_byte = '{8'h00, 8'h00};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs(0);
        check_reset_outputs(1);

        // Basic frame and CLK_DIV=1 frame.
        frame(0, 8'hAD, 8'h55);
        frame(1, 8'h81, 8'h80);

        // Start and data2send changes while busy must not disturb the frame.
        slave_byte[0] = 8'h55;
        exp_q.push_back('{id: 0, tx: 8'hAD, rx: 8'h55});
        pulse_start(0, 8'hAD);
        repeat (10) @(negedge clk);
        pulse_start(0, 8'hFF);
        wait_done(0);
        repeat (40) @(negedge clk);
        check("busy_no_second_frame", cs[0], 1);

        // Back-to-back frames with start held high and miso tied high.
        slave_byte[0] = 8'hFF;
        exp_q.push_back('{id: 0, tx: 8'h3C, rx: 8'hFF});
        exp_q.push_back('{id: 0, tx: 8'hC3, rx: 8'hFF});
        @(negedge clk);
        d2s[0]   = 8'h3C;
        start[0] = 1'b1;
        wait_cs_low(0);
        d2s[0]       = 8'hC3;
        gap_check[0] = 1'b1;
        wait_done(0);
        wait_cs_low(0);
        start[0] = 1'b0;
        wait_done(0);
        gap_check[0] = 1'b0;

        // Randomized frames on either instance.
        for (int k = 0; k < 8; k++) begin
            int id;
            id = int'($urandom_range(0, 1));
            frame(id, 8'($urandom), 8'($urandom));
        end

        // Stability: idle with random miso leaves outputs untouched.
        frame(0, 8'h5A, 8'hC7);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            stim_miso = 2'($urandom);
        end
        check("stable_rx",   d2r[0],  8'hC7);
        check("stable_cs",   cs[0],   1);
        check("stable_sclk", sclk[0], 0);

        // Abort mid-frame after the 4th rising sclk edge: no done, outputs reset.
        slave_byte[0] = 8'hA5;
        pulse_start(0, 8'h96);
        begin
            int n = 0;
            while (n < 100 && m_rises[0] < 4) begin @(negedge clk); n++; end
            check("abort_reached_4_edges", (m_rises[0] >= 4), 1);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs(0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_stays_idle", cs[0], 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
